// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock blocks: FSM encoding and digit widths.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } state_t;

    localparam int HOUR1_W = 2;   // hour tens digit, 0..2
    localparam int DIGIT_W = 4;   // all other BCD digits
    localparam int SEC_W   = 10;  // phase second counter

endpackage

// File: rtl/alarm_ctrl_edge_det.sv
// Registered rising-edge detector: rise pulses for one cycle, one cycle after d goes high.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Delay the input and register the 0->1 transition so the pulse is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: load strobe for the alarm register plus the
// armed / ringing / snoozed FSM with ring timeout and snooze limit.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_1s,
    input  logic               ld_req,
    input  logic               AL_ON,
    input  logic               STOP_al,
    input  logic               SNOOZE,
    input  logic [HOUR1_W-1:0] c_hour1,
    input  logic [DIGIT_W-1:0] c_hour0,
    input  logic [DIGIT_W-1:0] c_min1,
    input  logic [DIGIT_W-1:0] c_min0,
    input  logic [HOUR1_W-1:0] a_hour1,
    input  logic [DIGIT_W-1:0] a_hour0,
    input  logic [DIGIT_W-1:0] a_min1,
    input  logic [DIGIT_W-1:0] a_min0,
    output logic               LD_alarm,
    output logic               Alarm,
    output logic [1:0]         snooze_cnt,
    output logic [1:0]         state_o
);

    localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

    logic             match;
    logic [3:0]       raw;
    logic [3:0]       ev;
    logic             ld_e, stop_e, snz_e, m_rise;
    state_t           state, state_nx;
    logic [SEC_W-1:0] sec_cnt, sec_nx, sec_inc;
    logic [1:0]       snz_cnt, snz_nx;

    // Digit-wise compare; midnight wrap needs no special handling.
    assign match = (c_hour1 == a_hour1) && (c_hour0 == a_hour0) &&
                   (c_min1  == a_min1)  && (c_min0  == a_min0);

    assign raw = {match, SNOOZE, STOP_al, ld_req};

    edge_det u_edge [3:0] (
        .clk   (clk),
        .reset (reset),
        .d     (raw),
        .rise  (ev)
    );

    assign ld_e   = ev[0];
    assign stop_e = ev[1];
    assign snz_e  = ev[2];
    assign m_rise = ev[3];

    // Saturating increment: the counter never wraps inside a phase.
    assign sec_inc = (sec_cnt == '1) ? sec_cnt : sec_cnt + 1'b1;

    // Next-state logic; the if/else order encodes event priority.
    always_comb begin
        state_nx = state;
        sec_nx   = sec_cnt;
        snz_nx   = snz_cnt;
        if (ld_e) begin
            state_nx = AL_ON ? ST_ARMED : ST_IDLE;
            sec_nx   = '0;
            snz_nx   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (AL_ON) state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!AL_ON) begin
                        state_nx = ST_IDLE;
                    end else if (m_rise) begin
                        state_nx = ST_RINGING;
                        sec_nx   = '0;
                    end
                end
                ST_RINGING: begin
                    if (!AL_ON) begin
                        state_nx = ST_IDLE;
                        snz_nx   = '0;
                    end else if (stop_e || (snz_e && snz_cnt >= SNZ_MAX)) begin
                        state_nx = ST_ARMED;
                        snz_nx   = '0;
                    end else if (snz_e) begin
                        state_nx = ST_SNOOZED;
                        snz_nx   = snz_cnt + 1'b1;
                        sec_nx   = '0;
                    end else if (tick_1s) begin
                        if (sec_cnt == RING_LAST) begin
                            state_nx = ST_ARMED;
                            snz_nx   = '0;
                        end else begin
                            sec_nx = sec_inc;
                        end
                    end
                end
                ST_SNOOZED: begin
                    if (!AL_ON) begin
                        state_nx = ST_IDLE;
                        snz_nx   = '0;
                    end else if (stop_e) begin
                        state_nx = ST_ARMED;
                        snz_nx   = '0;
                    end else if (tick_1s) begin
                        if (sec_cnt == SNZ_LAST) begin
                            state_nx = ST_RINGING;
                            sec_nx   = '0;
                        end else begin
                            sec_nx = sec_inc;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State, phase counter and snooze count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            sec_cnt <= '0;
            snz_cnt <= '0;
        end else begin
            state   <= state_nx;
            sec_cnt <= sec_nx;
            snz_cnt <= snz_nx;
        end
    end

    assign LD_alarm   = ld_e;
    assign Alarm      = (state == ST_RINGING);
    assign snooze_cnt = snz_cnt;
    assign state_o    = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_alarm_ctrl;

    localparam int RING  = 5;
    localparam int SNZS  = 3;
    localparam int MAXS  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1s = 1'b0, ld_req = 1'b0, AL_ON = 1'b0, STOP_al = 1'b0, SNOOZE = 1'b0;
    logic [1:0] c_hour1 = 2'd0, a_hour1 = 2'd0;
    logic [3:0] c_hour0 = 4'd7, c_min1 = 4'd2, c_min0 = 4'd9;
    logic [3:0] a_hour0 = 4'd0, a_min1 = 4'd0, a_min0 = 4'd0;
    logic       LD_alarm, Alarm;
    logic [1:0] snooze_cnt, state_o;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZS), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s), .ld_req(ld_req), .AL_ON(AL_ON),
        .STOP_al(STOP_al), .SNOOZE(SNOOZE),
        .c_hour1(c_hour1), .c_hour0(c_hour0), .c_min1(c_min1), .c_min0(c_min0),
        .a_hour1(a_hour1), .a_hour0(a_hour0), .a_min1(a_min1), .a_min0(a_min0),
        .LD_alarm(LD_alarm), .Alarm(Alarm), .snooze_cnt(snooze_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase names: 0 idle, 1 armed, 2 ringing, 3 snoozed. Events become visible
    // one clock after the input level rises; the model acts on them at the next clock.
    int m_st, m_snz, m_ticks;
    bit m_ld, m_stop, m_snzp, m_mr;          // pending (visible) events
    bit p_ld, p_stop, p_snz, p_match;         // last sampled levels

    function automatic bit cur_match();
        return {c_hour1, c_hour0, c_min1, c_min0} == {a_hour1, a_hour0, a_min1, a_min0};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_snz = 0; m_ticks = 0;
            {m_ld, m_stop, m_snzp, m_mr} = '0;
            {p_ld, p_stop, p_snz, p_match} = '0;
        end else begin
            if (m_ld) begin
                m_st = AL_ON ? 1 : 0; m_snz = 0; m_ticks = 0;
            end else if (m_st == 0) begin
                if (AL_ON) m_st = 1;
            end else if (!AL_ON) begin
                m_st = 0; m_snz = 0;
            end else if (m_st == 1) begin
                if (m_mr) begin m_st = 2; m_ticks = 0; end
            end else if (m_st == 2) begin
                if (m_stop || (m_snzp && m_snz == MAXS)) begin
                    m_st = 1; m_snz = 0;
                end else if (m_snzp) begin
                    m_st = 3; m_snz++; m_ticks = 0;
                end else if (tick_1s) begin
                    m_ticks++;
                    if (m_ticks == RING) begin m_st = 1; m_snz = 0; end
                end
            end else begin
                if (m_stop) begin
                    m_st = 1; m_snz = 0;
                end else if (tick_1s) begin
                    m_ticks++;
                    if (m_ticks == SNZS) begin m_st = 2; m_ticks = 0; end
                end
            end
            m_ld   = ld_req & ~p_ld;     p_ld    = ld_req;
            m_stop = STOP_al & ~p_stop;  p_stop  = STOP_al;
            m_snzp = SNOOZE & ~p_snz;    p_snz   = SNOOZE;
            m_mr   = cur_match() & ~p_match; p_match = cur_match();
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_ld",    LD_alarm,   m_ld);
            chk("cyc_alarm", Alarm,      m_st == 2);
            chk("cyc_snz",   snooze_cnt, m_snz);
            chk("cyc_state", state_o,    m_st);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_min0(input logic [3:0] m);
        c_hour1 = 2'd0; c_hour0 = 4'd7; c_min1 = 4'd3; c_min0 = m;
    endtask

    task automatic tick();
        @(negedge clk) tick_1s = 1'b1;
        @(negedge clk) tick_1s = 1'b0;
    endtask

    task automatic press_snz();
        @(negedge clk) SNOOZE = 1'b1;
        @(negedge clk) SNOOZE = 1'b0;
        cyc(1);
    endtask

    task automatic ring(input string name);
        set_min0(4'd1); cyc(2);
        set_min0(4'd0); cyc(2);
        chk(name, Alarm, 1);
    endtask

    initial begin
        // 1: reset and load path
        AL_ON = 1'b1;
        cyc(2);
        chk("rst_state", state_o, 0);
        chk("rst_alarm", Alarm, 0);
        chk("rst_ld",    LD_alarm, 0);
        reset = 1'b1;
        cmp_en = 1;
        cyc(1);
        chk("t1_armed", state_o, 1);
        begin
            int pulses = 0;
            ld_req = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (LD_alarm) pulses++;
            end
            ld_req = 1'b0;
            chk("t1_one_pulse", pulses, 1);
        end
        a_hour1 = 2'd0; a_hour0 = 4'd7; a_min1 = 4'd3; a_min0 = 4'd0;
        chk("t1_state", state_o, 1);

        // 2: ring timeout after RING ticks, no re-ring inside the minute
        c_hour1 = 2'd0; c_hour0 = 4'd7; c_min1 = 4'd2; c_min0 = 4'd9;
        cyc(2);
        set_min0(4'd0); cyc(1);
        chk("t2_not_yet", Alarm, 0);
        cyc(1);
        chk("t2_ring", Alarm, 1);
        chk("t2_model_ring", m_st, 2);
        repeat (RING - 1) tick();
        chk("t2_still", Alarm, 1);
        tick();
        chk("t2_timeout", Alarm, 0);
        chk("t2_armed", state_o, 1);
        cyc(10);
        chk("t2_no_rering", Alarm, 0);

        // 3: snooze limit
        ring("t3_ring");
        press_snz();
        chk("t3_snz1_al", Alarm, 0);
        chk("t3_snz1_cnt", snooze_cnt, 1);
        chk("t3_model_cnt", m_snz, 1);
        repeat (SNZS - 1) tick();
        chk("t3_wait", Alarm, 0);
        tick();
        chk("t3_rering1", Alarm, 1);
        press_snz();
        chk("t3_snz2_cnt", snooze_cnt, 2);
        repeat (SNZS) tick();
        chk("t3_rering2", Alarm, 1);
        press_snz();
        chk("t3_limit_state", state_o, 1);
        chk("t3_limit_cnt", snooze_cnt, 0);

        // 4: priority
        ring("t4_ring");
        @(negedge clk) begin STOP_al = 1'b1; SNOOZE = 1'b1; end
        @(negedge clk) begin STOP_al = 1'b0; SNOOZE = 1'b0; end
        cyc(1);
        chk("t4_both_state", state_o, 1);
        chk("t4_both_cnt", snooze_cnt, 0);
        ring("t4_ring2");
        press_snz();
        chk("t4_snoozed", state_o, 3);
        @(negedge clk) ld_req = 1'b1;
        @(negedge clk) ld_req = 1'b0;
        chk("t4_ld_pulse", LD_alarm, 1);
        cyc(1);
        chk("t4_ld_state", state_o, 1);
        chk("t4_ld_alarm", Alarm, 0);
        chk("t4_ld_cnt", snooze_cnt, 0);

        // 5: enable
        ring("t5_ring");
        @(negedge clk) AL_ON = 1'b0;
        cyc(1);
        chk("t5_off_state", state_o, 0);
        chk("t5_off_alarm", Alarm, 0);
        AL_ON = 1'b1;
        cyc(1);
        chk("t5_on_state", state_o, 1);
        cyc(10);
        chk("t5_no_ring", Alarm, 0);

        // 6: asynchronous reset mid-ring
        ring("t6_ring");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_alarm", Alarm, 0);
        chk("t6_async_state", state_o, 0);
        chk("t6_model_state", m_st, 0);
        set_min0(4'd5);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("t6_release", state_o, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            tick_1s = ($urandom_range(3) == 0);
            if ($urandom_range(9) == 0)   STOP_al = ~STOP_al & ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0)   SNOOZE  = ~SNOOZE;
            if ($urandom_range(79) == 0)  ld_req  = ~ld_req;
            if ($urandom_range(99) == 0)  AL_ON   = ~AL_ON;
            if ($urandom_range(11) == 0)  set_min0(($urandom_range(1) == 0) ? 4'd0 : 4'd1);
        end

        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
